// File: rtl/ifm_chunk_pkg.sv
// Shared types and sizing for the IFM chunk writer and its beat compactor.
// BUS_SIZE / WR_DAT_CYC_NUM may be overridden by defining the macros before this file.
`ifndef BUS_SIZE
`define BUS_SIZE 8
`endif
`ifndef WR_DAT_CYC_NUM
`define WR_DAT_CYC_NUM 4
`endif

package ifm_chunk_pkg;
    localparam int BUS_SIZE       = `BUS_SIZE;
    localparam int WR_DAT_CYC_NUM = `WR_DAT_CYC_NUM;
    localparam int BEAT_CNT_W     = (WR_DAT_CYC_NUM > 1) ? $clog2(WR_DAT_CYC_NUM) : 1;
    localparam int NNZ_W          = $clog2(BUS_SIZE) + 1;
    localparam int IDX_W          = (NNZ_W > 1) ? NNZ_W - 1 : 1;

    typedef logic [BUS_SIZE-1:0][7:0] beat_t;
    typedef logic [BUS_SIZE-1:0]      smap_t;
    typedef logic [NNZ_W-1:0]         nnz_t;

    typedef enum logic {S_FILL = 1'b0, S_WAIT = 1'b1} state_e;
endpackage

// File: rtl/sparse_beat_compactor.sv
// Combinational beat compression: sparsemap, nonzero bytes packed to low slots, popcount.
module sparse_beat_compactor
    import ifm_chunk_pkg::*;
(
    input  beat_t data,
    output smap_t sparsemap,
    output beat_t nonzero_data,
    output nnz_t  nnz_count
);

    nnz_t slot;

    // Running slot index doubles as the prefix popcount of lower sparsemap bits.
    always_comb begin
        sparsemap    = '0;
        nonzero_data = '0;
        slot         = '0;
        for (int i = 0; i < BUS_SIZE; i++) begin
            sparsemap[i] = |data[i];
            if (sparsemap[i]) begin
                nonzero_data[slot[IDX_W-1:0]] = data[i];
                slot = slot + 1'b1;
            end
        end
        nnz_count = slot;
    end

endmodule

// File: rtl/ifm_chunk_writer.sv
// Producer side of the IFM ping-pong chunk buffer: compresses dense beats, writes them
// into alternating banks, and stalls input while the next bank is still unconsumed.
module ifm_chunk_writer
    import ifm_chunk_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  beat_t                 in_data_i,
    output smap_t                 wr_sparsemap_o,
    output beat_t                 wr_nonzero_data_o,
    output logic                  wr_valid_o,
    output logic [BEAT_CNT_W-1:0] wr_count_o,
    output logic                  wr_sel_o,
    output logic                  rd_sel_o,
    output logic                  chunk_ready_o,
    input  logic                  chunk_consumed_i,
    output nnz_t                  nnz_count_o
);

    state_e                state, state_next;
    logic                  wr_bank, wr_bank_next;
    logic                  rd_bank, rd_bank_next;
    logic [BEAT_CNT_W-1:0] beat_cnt, beat_cnt_next;
    logic [1:0]            full, full_next;

    smap_t                 smap_p0;
    beat_t                 nz_p0;
    nnz_t                  nnz_p0;

    smap_t                 smap_p1;
    beat_t                 nz_p1;
    nnz_t                  nnz_p1;
    logic [BEAT_CNT_W-1:0] cnt_p1;
    logic                  sel_p1;
    logic                  vld_p1;

    logic accept;
    logic consume_fire;
    logic last_beat;

    sparse_beat_compactor u_compactor (
        .data         (in_data_i),
        .sparsemap    (smap_p0),
        .nonzero_data (nz_p0),
        .nnz_count    (nnz_p0)
    );

    // Ready is gated by reset so it reads 0 while the block is held in reset.
    assign in_ready_o    = rst_i && (state == S_FILL);
    assign accept        = in_valid_i && in_ready_o;
    assign consume_fire  = chunk_consumed_i && full[rd_bank];
    assign last_beat     = (beat_cnt == BEAT_CNT_W'(WR_DAT_CYC_NUM - 1));
    assign chunk_ready_o = full[rd_bank];
    assign rd_sel_o      = rd_bank;

    always_comb begin
        state_next    = state;
        wr_bank_next  = wr_bank;
        rd_bank_next  = rd_bank;
        beat_cnt_next = beat_cnt;
        full_next     = full;
        if (consume_fire) begin
            full_next[rd_bank] = 1'b0;
            rd_bank_next       = ~rd_bank;
        end
        if (accept) begin
            if (last_beat) begin
                beat_cnt_next      = '0;
                full_next[wr_bank] = 1'b1;
                wr_bank_next       = ~wr_bank;
            end else begin
                beat_cnt_next = beat_cnt + 1'b1;
            end
        end
        // full_next already reflects a same-edge consume, so a freed target bank skips S_WAIT.
        case (state)
            S_FILL:  if (accept && last_beat && full_next[~wr_bank]) state_next = S_WAIT;
            S_WAIT:  if (!full_next[wr_bank]) state_next = S_FILL;
            default: state_next = S_FILL;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= S_FILL;
        else        state <= state_next;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            beat_cnt <= '0;
            full     <= '0;
        end else begin
            wr_bank  <= wr_bank_next;
            rd_bank  <= rd_bank_next;
            beat_cnt <= beat_cnt_next;
            full     <= full_next;
        end
    end

    // p0 -> p1: compressed beat registered onto the buffer write port
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld_p1  <= 1'b0;
            smap_p1 <= '0;
            nz_p1   <= '0;
            nnz_p1  <= '0;
            cnt_p1  <= '0;
            sel_p1  <= 1'b0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                smap_p1 <= smap_p0;
                nz_p1   <= nz_p0;
                nnz_p1  <= nnz_p0;
                cnt_p1  <= beat_cnt;
                sel_p1  <= wr_bank;
            end
        end
    end

    assign wr_valid_o        = vld_p1;
    assign wr_sparsemap_o    = smap_p1;
    assign wr_nonzero_data_o = nz_p1;
    assign nnz_count_o       = nnz_p1;
    assign wr_count_o        = cnt_p1;
    assign wr_sel_o          = sel_p1;

endmodule

// File: tb/tb_ifm_chunk_writer.sv
// Self-checking bench for ifm_chunk_writer: directed scenarios plus random traffic
// compared against an occupancy-based reference model.
module tb_ifm_chunk_writer;
    import ifm_chunk_pkg::*;

    localparam int N = WR_DAT_CYC_NUM;

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    beat_t                 in_data;
    smap_t                 wr_sparsemap;
    beat_t                 wr_nonzero_data;
    logic                  wr_valid;
    logic [BEAT_CNT_W-1:0] wr_count;
    logic                  wr_sel;
    logic                  rd_sel;
    logic                  chunk_ready;
    logic                  chunk_consumed;
    nnz_t                  nnz_count;

    int checks   = 0;
    int failures = 0;

    // Reference model: total beats accepted and chunks consumed since reset.
    int    beats    = 0;
    int    consumed = 0;
    smap_t e_smap   = '0;
    beat_t e_nz     = '0;
    int    e_nnz    = 0;
    int    e_cnt    = 0;
    int    e_sel    = 0;

    ifm_chunk_writer dut (
        .clk_i             (clk),
        .rst_i             (rst_n),
        .in_valid_i        (in_valid),
        .in_ready_o        (in_ready),
        .in_data_i         (in_data),
        .wr_sparsemap_o    (wr_sparsemap),
        .wr_nonzero_data_o (wr_nonzero_data),
        .wr_valid_o        (wr_valid),
        .wr_count_o        (wr_count),
        .wr_sel_o          (wr_sel),
        .rd_sel_o          (rd_sel),
        .chunk_ready_o     (chunk_ready),
        .chunk_consumed_i  (chunk_consumed),
        .nnz_count_o       (nnz_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int occupancy();
        return beats / N - consumed;
    endfunction

    task automatic model_compress(input beat_t d);
        byte unsigned q[$];
        e_smap = '0;
        e_nz   = '0;
        for (int i = 0; i < BUS_SIZE; i++) begin
            if (d[i] != 8'd0) begin
                e_smap[i] = 1'b1;
                q.push_back(d[i]);
            end
        end
        for (int j = 0; j < q.size(); j++) e_nz[j] = q[j];
        e_nnz = q.size();
    endtask

    function automatic beat_t rand_beat();
        beat_t b;
        for (int i = 0; i < BUS_SIZE; i++)
            b[i] = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        return b;
    endfunction

    task automatic check_state(input logic acc);
        chk("wr_valid", wr_valid, acc);
        chk("wr_sparsemap", wr_sparsemap, e_smap);
        chk("wr_nonzero", wr_nonzero_data, e_nz);
        chk("nnz_count", nnz_count, e_nnz);
        chk("wr_count", wr_count, e_cnt);
        chk("wr_sel", wr_sel, e_sel);
        chk("in_ready", in_ready, occupancy() < 2);
        chk("chunk_ready", chunk_ready, occupancy() > 0);
        chk("rd_sel", rd_sel, consumed % 2);
    endtask

    // One clock: drive inputs, advance the model by what the edge should accept, check.
    task automatic cycle(input logic v, input beat_t d, input logic c);
        logic acc, cf;
        in_valid       = v;
        in_data        = d;
        chunk_consumed = c;
        acc = v && (occupancy() < 2);
        cf  = c && (occupancy() > 0);
        @(posedge clk);
        #1;
        if (acc) begin
            model_compress(d);
            e_cnt = beats % N;
            e_sel = (beats / N) % 2;
            beats++;
        end
        if (cf) consumed++;
        in_valid       = 1'b0;
        chunk_consumed = 1'b0;
        check_state(acc);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_wr_valid"}, wr_valid, 0);
        chk({tag, "_smap"}, wr_sparsemap, 0);
        chk({tag, "_nz"}, wr_nonzero_data, 0);
        chk({tag, "_nnz"}, nnz_count, 0);
        chk({tag, "_count"}, wr_count, 0);
        chk({tag, "_wr_sel"}, wr_sel, 0);
        chk({tag, "_rd_sel"}, rd_sel, 0);
        chk({tag, "_chunk_ready"}, chunk_ready, 0);
    endtask

    // Asynchronous assert mid-cycle, outputs checked before any clock edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_all_zero(tag);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        beats    = 0;
        consumed = 0;
        e_smap   = '0;
        e_nz     = '0;
        e_nnz    = 0;
        e_cnt    = 0;
        e_sel    = 0;
        #1;
        chk({tag, "_ready_after_release"}, in_ready, 1);
    endtask

    initial begin
        beat_t d;
        rst_n          = 1'b0;
        in_valid       = 1'b0;
        in_data        = '0;
        chunk_consumed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        do_reset("reset2");

        // Sparse beat {0,5,0,7,0..}
        d    = '0;
        d[1] = 8'd5;
        d[3] = 8'd7;
        cycle(1'b1, d, 1'b0);
        chk("t1_smap", wr_sparsemap, 128'h0A);
        chk("t1_nz0", wr_nonzero_data[0], 8'd5);
        chk("t1_nz1", wr_nonzero_data[1], 8'd7);
        chk("t1_nnz", nnz_count, 2);
        chk("t1_valid", wr_valid, 1);
        cycle(1'b0, rand_beat(), 1'b0);
        chk("t1_hold_smap", wr_sparsemap, 128'h0A);

        // Two full chunks without consume: second bank fill stalls input
        do_reset("t2_rst");
        for (int i = 0; i < 2 * N; i++) cycle(1'b1, rand_beat(), 1'b0);
        chk("t2_last_sel", wr_sel, 1);
        chk("t2_last_count", wr_count, N - 1);
        chk("t2_ready", in_ready, 0);
        chk("t2_chunk_ready", chunk_ready, 1);
        chk("t2_rd_sel", rd_sel, 0);
        for (int i = 0; i < 3; i++) cycle(1'b1, rand_beat(), 1'b0);

        // Consume bank 0: ready returns in the next cycle and bank 0 refills
        cycle(1'b0, rand_beat(), 1'b1);
        chk("t3_rd_sel", rd_sel, 1);
        chk("t3_ready", in_ready, 1);
        for (int i = 0; i < N; i++) begin
            cycle(1'b1, rand_beat(), 1'b0);
            chk("t3_wr_sel", wr_sel, 0);
        end

        // Free bank 1, then consume bank 0 on the same edge bank 1's last beat lands
        cycle(1'b0, rand_beat(), 1'b1);
        for (int i = 0; i < N - 1; i++) cycle(1'b1, rand_beat(), 1'b0);
        cycle(1'b1, rand_beat(), 1'b1);
        chk("t4_ready", in_ready, 1);
        chk("t4_wr_sel", wr_sel, 1);
        chk("t4_rd_sel", rd_sel, 1);
        chk("t4_chunk_ready", chunk_ready, 1);

        // Extreme beats
        cycle(1'b1, '0, 1'b0);
        chk("t5_zero_smap", wr_sparsemap, 0);
        chk("t5_zero_nnz", nnz_count, 0);
        cycle(1'b1, '1, 1'b0);
        chk("t5_ff_smap", wr_sparsemap, {BUS_SIZE{1'b1}});
        chk("t5_ff_nnz", nnz_count, BUS_SIZE);

        // Random traffic
        for (int i = 0; i < 300; i++)
            cycle($urandom_range(0, 3) != 0, rand_beat(), $urandom_range(0, 5) == 0);

        // Reset mid-chunk at beat 2
        do_reset("t6_pre");
        cycle(1'b1, rand_beat(), 1'b0);
        cycle(1'b1, rand_beat(), 1'b0);
        do_reset("t6_midchunk");
        cycle(1'b0, rand_beat(), 1'b1);
        chk("t6_spurious_rd_sel", rd_sel, 0);
        cycle(1'b1, rand_beat(), 1'b0);
        chk("t6_count", wr_count, 0);
        chk("t6_sel", wr_sel, 0);

        // Reset while stalled
        for (int i = 0; i < 2 * N; i++) cycle(1'b1, rand_beat(), 1'b0);
        chk("t6_wait_ready", in_ready, 0);
        do_reset("t6_midwait");
        cycle(1'b1, rand_beat(), 1'b0);
        chk("t6b_count", wr_count, 0);
        chk("t6b_sel", wr_sel, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
